// File: rtl/neuron_array_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_array_sequencer
//
// Host-side controller for the neuron array. Programs the active-neuron
// count, streams the per-neuron config words onto the shared ins bus, runs
// the anneal for a requested number of cycles, then raises rd and forwards
// the array's readout words to the host as a valid/last stream. A start with
// skip_load reruns the anneal on the config already held by the array.
//
// Ports
//   clk, reset_l            clock, asynchronous active-low reset
//   start                   1-cycle request, only honoured while idle
//   skip_load               with start: rerun without reprogramming
//   num_active              with start: neurons to program (0 is illegal)
//   run_cycles              with start: anneal length in cycles
//   cfg_valid/cfg_data      host config word stream
//   cfg_ready               high while config words are being accepted
//   ins, rd                 array command/data bus and readout request
//   outs, readDone          array readout word and final-word flag
//   res_valid/data/last     result stream to host (no backpressure)
//   busy                    high whenever not idle
//   done                    1-cycle pulse on normal completion
//   err                     sticky error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module neuron_array_sequencer #(
    parameter int unsigned FP_DATA_WIDTH    = 16,
    parameter int unsigned NEURON_ID_WIDTH  = 8,
    parameter int unsigned NUM_NEURON       = 256,
    parameter int unsigned WORDS_PER_NEURON = 4,
    parameter int unsigned RUN_CNT_WIDTH    = 16
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       start,
    input  logic                       skip_load,
    input  logic [NEURON_ID_WIDTH-1:0] num_active,
    input  logic [RUN_CNT_WIDTH-1:0]   run_cycles,
    input  logic                       cfg_valid,
    input  logic [FP_DATA_WIDTH-1:0]   cfg_data,
    output logic                       cfg_ready,
    output logic [FP_DATA_WIDTH-1:0]   ins,
    output logic                       rd,
    input  logic [FP_DATA_WIDTH-1:0]   outs,
    input  logic                       readDone,
    output logic                       res_valid,
    output logic [FP_DATA_WIDTH-1:0]   res_data,
    output logic                       res_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned WCNT_W     = NEURON_ID_WIDTH + 3;
    localparam int unsigned READ_LIMIT = NUM_NEURON / 16 + 4;
    localparam int unsigned RCNT_W     = $clog2(READ_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_N,
        S_MARK,
        S_LOAD,
        S_RUN,
        S_REQ,
        S_READ
    } state_t;

    state_t                     state, state_n;
    logic [FP_DATA_WIDTH-1:0]   ins_q, ins_n;
    logic                       rd_q, rd_n;
    logic                       rv_q, rv_n;
    logic [FP_DATA_WIDTH-1:0]   rdata_q, rdata_n;
    logic                       rlast_q, rlast_n;
    logic                       done_q, done_n;
    logic                       err_q, err_n;
    logic                       loaded_q, loaded_n;
    logic [NEURON_ID_WIDTH-1:0] num_q, num_n;
    logic [RUN_CNT_WIDTH-1:0]   runlen_q, runlen_n;
    logic [RUN_CNT_WIDTH-1:0]   runcnt_q, runcnt_n;
    logic [WCNT_W-1:0]          wcnt_q, wcnt_n;
    logic [RCNT_W-1:0]          rcnt_q, rcnt_n;
    logic [WCNT_W-1:0]          load_target;

    assign load_target = WCNT_W'(num_q) * WCNT_W'(WORDS_PER_NEURON);

    // cfg_ready and busy decode the state register directly, so they are
    // aligned with the state the registered bus outputs belong to.
    assign cfg_ready = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign ins       = ins_q;
    assign rd        = rd_q;
    assign res_valid = rv_q;
    assign res_data  = rdata_q;
    assign res_last  = rlast_q;
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state    <= S_IDLE;
            ins_q    <= '0;
            rd_q     <= 1'b0;
            rv_q     <= 1'b0;
            rdata_q  <= '0;
            rlast_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
            num_q    <= '0;
            runlen_q <= '0;
            runcnt_q <= '0;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
        end else begin
            state    <= state_n;
            ins_q    <= ins_n;
            rd_q     <= rd_n;
            rv_q     <= rv_n;
            rdata_q  <= rdata_n;
            rlast_q  <= rlast_n;
            done_q   <= done_n;
            err_q    <= err_n;
            loaded_q <= loaded_n;
            num_q    <= num_n;
            runlen_q <= runlen_n;
            runcnt_q <= runcnt_n;
            wcnt_q   <= wcnt_n;
            rcnt_q   <= rcnt_n;
        end
    end

    // Next-state logic also computes the output values for the state being
    // entered, so every registered output lines up with its state.
    always_comb begin
        state_n  = state;
        ins_n    = '0;
        rd_n     = 1'b0;
        rv_n     = 1'b0;
        rdata_n  = '0;
        rlast_n  = 1'b0;
        done_n   = 1'b0;
        err_n    = err_q;
        loaded_n = loaded_q;
        num_n    = num_q;
        runlen_n = runlen_q;
        runcnt_n = runcnt_q;
        wcnt_n   = wcnt_q;
        rcnt_n   = rcnt_q;

        case (state)
            S_IDLE: begin
                ins_n = FP_DATA_WIDTH'(num_q);
                if (start) begin
                    err_n = 1'b0;
                    if (num_active == '0) begin
                        err_n = 1'b1;
                    end else if (skip_load) begin
                        if (loaded_q) begin
                            state_n  = S_RUN;
                            runlen_n = run_cycles;
                            runcnt_n = run_cycles;
                            ins_n    = '0;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        // Reprogramming overwrites the array, so the old
                        // config is no longer valid for a rerun.
                        state_n  = S_SET_N;
                        num_n    = num_active;
                        runlen_n = run_cycles;
                        loaded_n = 1'b0;
                        ins_n    = FP_DATA_WIDTH'(num_active);
                    end
                end
            end

            S_SET_N: begin
                state_n = S_MARK;
                ins_n   = '1;
            end

            S_MARK: begin
                state_n = S_LOAD;
                wcnt_n  = '0;
            end

            S_LOAD: begin
                if (cfg_valid) begin
                    ins_n = cfg_data;
                    if (wcnt_q == load_target - WCNT_W'(1)) begin
                        loaded_n = 1'b1;
                        state_n  = S_RUN;
                        runcnt_n = runlen_q;
                    end else begin
                        wcnt_n = wcnt_q + WCNT_W'(1);
                    end
                end else if (wcnt_q != '0) begin
                    // The array consumes one word per cycle once loading has
                    // begun; a gap corrupts the programming sequence.
                    err_n    = 1'b1;
                    loaded_n = 1'b0;
                    state_n  = S_IDLE;
                    ins_n    = FP_DATA_WIDTH'(num_q);
                end
            end

            S_RUN: begin
                if (runcnt_q == '0) begin
                    state_n = S_REQ;
                    rd_n    = 1'b1;
                end else begin
                    runcnt_n = runcnt_q - RUN_CNT_WIDTH'(1);
                end
            end

            S_REQ: begin
                state_n = S_READ;
                rd_n    = 1'b1;
                rcnt_n  = '0;
            end

            S_READ: begin
                rv_n    = 1'b1;
                rdata_n = outs;
                if (readDone) begin
                    rlast_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                    ins_n   = FP_DATA_WIDTH'(num_q);
                end else if (rcnt_q == RCNT_W'(READ_LIMIT - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                    ins_n   = FP_DATA_WIDTH'(num_q);
                end else begin
                    rcnt_n = rcnt_q + RCNT_W'(1);
                    rd_n   = 1'b1;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule
